// File: rtl/inv_bist.sv
// Built-in self test for a 3-input, 1-output logic cell: sweeps all 8 input vectors and checks Y1 against a truth table.
// Define INV_BIST_GRAY_EN to sweep the vectors in Gray-code order instead of binary order.
module inv_bist #(
  parameter int          DUT_LAT = 1,
  parameter logic [7:0]  EXP_TT  = 8'h7F,
  parameter int          PASSES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       X1,
  output logic       X2,
  output logic       X3,
  input  logic       Y1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam logic [6:0] LAST     = 7'(8 * PASSES - 1);
  localparam logic [2:0] DRN_LAST = 3'(DUT_LAT - 1);

  state_t     state, state_nxt;
  logic [6:0] cnt, cnt_nxt;
  logic [2:0] drn;
  logic       run_start, drive_last;

  logic       vld_p0, exp_p0;
  logic [2:0] vec_p0;
  logic       vld_pt, exp_pt;
  logic [2:0] vec_pt;
  logic       mismatch;

  function automatic logic [2:0] vec_of(input logic [2:0] idx);
`ifdef INV_BIST_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    run_start  = 1'b0;
    drive_last = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          run_start = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == LAST) begin
          drive_last = 1'b1;
          state_nxt  = (DUT_LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drn == DRN_LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0: the vector currently on X1..X3 and its expected response
  assign cnt_nxt = cnt + 7'd1;
  assign vld_p0  = (state == DRIVE);
  assign vec_p0  = {X1, X2, X3};
  assign exp_p0  = EXP_TT[vec_p0];

  // Stages 1..DUT_LAT: compare slots delayed to line up with the DUT response
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign vld_pt = vld_p0;
      assign vec_pt = vec_p0;
      assign exp_pt = exp_p0;
    end else begin : g_lat
      logic [DUT_LAT-1:0] vld_p1;
      logic [DUT_LAT-1:0] exp_p1;
      logic [2:0]         vec_p1 [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst || run_start) begin
          vld_p1 <= '0;
        end else begin
          vld_p1[0] <= vld_p0;
          for (int i = 1; i < DUT_LAT; i++) vld_p1[i] <= vld_p1[i-1];
        end
      end

      always_ff @(posedge clk) begin
        exp_p1[0] <= exp_p0;
        vec_p1[0] <= vec_p0;
        for (int i = 1; i < DUT_LAT; i++) begin
          exp_p1[i] <= exp_p1[i-1];
          vec_p1[i] <= vec_p1[i-1];
        end
      end

      assign vld_pt = vld_p1[DUT_LAT-1];
      assign vec_pt = vec_p1[DUT_LAT-1];
      assign exp_pt = exp_p1[DUT_LAT-1];
    end
  endgenerate

  // Pipeline tail: compare against Y1 only when a valid slot has arrived
  assign mismatch = vld_pt && (Y1 != exp_pt);

  always_ff @(posedge clk) begin
    if (rst) begin
      {X1, X2, X3}   <= 3'd0;
      cnt            <= '0;
      drn            <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
    end else if (run_start) begin
      {X1, X2, X3}   <= vec_of(3'd0);
      cnt            <= '0;
      drn            <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
    end else begin
      if (state == DRIVE) begin
        if (drive_last) begin
          {X1, X2, X3} <= 3'd0;
        end else begin
          cnt          <= cnt_nxt;
          {X1, X2, X3} <= vec_of(cnt_nxt[2:0]);
        end
      end
      if (state == DRAIN) drn <= drn + 3'd1;
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        // err_cnt never returns to zero within a run, so zero marks the first miss
        if (err_cnt == 4'd0) first_fail_vec <= vec_pt;
      end
    end
  end

  assign busy = (state == DRIVE) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 4'd0);

endmodule

// File: tb/tb_inv_bist.sv
// Bench for inv_bist: three instances (latency 1/2/0) driven by behavioural NAND3 cells with fault injection.
module tb_inv_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  int         mode = 0;          // 0 golden, 1 Y1 stuck-at-1, 2 Y1 stuck-at-0
  int         checks = 0;
  int         failures = 0;
  logic [4:0] sb[$];

  logic [2:0] xa, xb, xc;
  logic       ya, yb, yc;
  logic       ya_r, yb_s1, yb_s2;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [3:0] err_a, err_b, err_c;
  logic [2:0] ffv_a, ffv_b, ffv_c;

  always #5 clk = ~clk;

  inv_bist #(.DUT_LAT(1), .EXP_TT(8'h7F), .PASSES(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .X1(xa[2]), .X2(xa[1]), .X3(xa[0]), .Y1(ya),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_fail_vec(ffv_a));
  inv_bist #(.DUT_LAT(2), .EXP_TT(8'h7F), .PASSES(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .X1(xb[2]), .X2(xb[1]), .X3(xb[0]), .Y1(yb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_fail_vec(ffv_b));
  inv_bist #(.DUT_LAT(0), .EXP_TT(8'h7F), .PASSES(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .X1(xc[2]), .X2(xc[1]), .X3(xc[0]), .Y1(yc),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .first_fail_vec(ffv_c));

  // Cells under test: NAND3 with 1, 2 and 0 cycles of latency
  always @(posedge clk) begin
    ya_r  <= ~&xa;
    yb_s1 <= ~&xb;
    yb_s2 <= yb_s1;
  end
  assign ya = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ya_r;
  assign yb = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : yb_s2;
  assign yc = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ~&xc;

  wire [11:0] out_a = {busy_a, done_a, pass_a, err_a, ffv_a, xa};
  wire [11:0] out_b = {busy_b, done_b, pass_b, err_b, ffv_b, xb};
  wire [11:0] out_c = {busy_c, done_c, pass_c, err_c, ffv_c, xc};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] vec_order(input int i);
    logic [2:0] b;
    b = 3'(i);
`ifdef INV_BIST_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Expected {done, pass, err_cnt, first_fail_vec} after a full run
  function automatic logic [8:0] exp_final(input int m, input int passes);
    int         e;
    logic [2:0] f, v;
    logic       y;
    e = 0;
    f = 3'd0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 8; i++) begin
        v = vec_order(i);
        y = (m == 1) ? 1'b1 : (m == 2) ? 1'b0 : ~&v;
        if (y != ~&v) begin
          if (e == 0) f = v;
          if (e < 15) e++;
        end
      end
    return {1'b1, (e == 0), 4'(e), f};
  endfunction

  task automatic run_bist(input int m, input bit hold);
    logic [4:0] w;
    logic [2:0] xs[$];
    int         k, nb, nc;
    mode = m;
    sb.delete();
    for (int i = 0; i < 10; i++)
      sb.push_back(i < 8 ? {2'b10, vec_order(i)} : (i == 8 ? 5'b10000 : 5'b01000));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 if (!hold) start = 1'b0;
    k = 0; nb = 0; nc = 0;
    while (k < 60) begin
      @(negedge clk);
      if (hold && k == 5) start = 1'b0;
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("a_cycle", {busy_a, done_a, xa}, w);
      end
      if (busy_b) nb++;
      if (busy_c) begin
        nc++;
        xs.push_back(xc);
      end
      k++;
      if (sb.size() == 0 && done_b && done_c) break;
    end
    check("run_timeout", {done_b, done_c}, 2'b11);
    check("b_busy_cycles", nb, 26);
    check("c_busy_cycles", nc, 8);
    check("c_order_len", xs.size(), 8);
    for (int i = 0; i < xs.size() && i < 8; i++) check("c_order", xs[i], vec_order(i));
    check("a_final", {done_a, pass_a, err_a, ffv_a}, exp_final(m, 1));
    check("b_final", {done_b, pass_b, err_b, ffv_b}, exp_final(m, 3));
    check("c_final", {done_c, pass_c, err_c, ffv_c}, exp_final(m, 1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", out_a, 12'd0);
    check("reset_b", out_b, 12'd0);
    check("reset_c", out_c, 12'd0);
    #1 rst = 1'b0;

    run_bist(0, 1'b0);
    repeat (3) @(negedge clk);
    check("a_done_hold", {done_a, pass_a, err_a, ffv_a}, 9'b1_1_0000_000);
    run_bist(1, 1'b0);
    run_bist(2, 1'b0);
    run_bist(0, 1'b1);

    // Reset in the 4th DRIVE cycle of a failing run
    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_a", out_a, 12'd0);
    check("midrun_rst_b", out_b, 12'd0);
    check("midrun_rst_c", out_c, 12'd0);
    rst = 1'b0;
    run_bist(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_bist.md
INV_BIST -- requirements
Module: inv_bist

Interface
REQ-001 Parameter DUT_LAT, default 1: DUT input-to-output latency in clock cycles; legal range 0..4.
REQ-002 Parameter EXP_TT, default 8'h7F: expected Y1 truth table, indexed by {X1,X2,X3}; default is NAND3.
REQ-003 Parameter PASSES, default 1: number of full 8-vector sweeps per run; legal range 1..15.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request, sampled on each rising edge.
REQ-007 X1  output  1  stimulus MSB of the vector, registered.
REQ-008 X2  output  1  stimulus middle bit of the vector, registered.
REQ-009 X3  output  1  stimulus LSB of the vector, registered.
REQ-010 Y1  input  1  DUT response under check.
REQ-011 busy  output  1  high in DRIVE and DRAIN.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  high in DONE when err_cnt == 0; low otherwise.
REQ-014 err_cnt  output  4  mismatch count, saturating at 15.
REQ-015 first_fail_vec  output  3  {X1,X2,X3} of the first mismatch; 0 if no mismatch.

Function
REQ-016 The FSM SHALL have four states: IDLE, DRIVE, DRAIN, DONE.
REQ-017 IDLE->DRIVE on start=1; err_cnt, first_fail_vec, vector counter and pipeline SHALL clear on that edge.
REQ-018 In DRIVE, one vector per cycle SHALL appear on X1..X3 from the first DRIVE cycle: binary order 0..7, repeated PASSES times.
REQ-019 DRIVE SHALL last exactly 8*PASSES cycles, then go to DRAIN; if DUT_LAT=0, it goes directly to DONE.
REQ-020 DRAIN SHALL last exactly DUT_LAT cycles, then go to DONE.
REQ-021 X1..X3 SHALL be 0 in IDLE, DRAIN and DONE.
REQ-022 A vector driven in cycle n SHALL be compared with Y1 at the rising edge ending cycle n+DUT_LAT.
- Compare rule: Y1 != EXP_TT[vec].
- Expected bit, vector and valid flag SHALL travel through a DUT_LAT-deep shift register.
REQ-023 On each mismatch, err_cnt SHALL increment, holding at 15.
REQ-024 On the first mismatch of a run, first_fail_vec SHALL capture the vector; later mismatches SHALL NOT change it.
REQ-025 In DONE, start=1 SHALL begin a new run exactly as from IDLE.
REQ-026 start SHALL be ignored in DRIVE and DRAIN.
REQ-027 DONE outputs SHALL hold until the next start or reset.
REQ-028 Y1 SHALL be ignored whenever no valid compare slot is at the pipeline tail.

Reset
REQ-029 While rst=1, at the next edge the block SHALL enter IDLE with all outputs 0, including X1..X3.
REQ-030 rst SHALL take priority over start.
REQ-031 On rst mid-run, in-flight compares SHALL be discarded.

Configuration
REQ-032 With INV_BIST_GRAY_EN defined, the vector order SHALL be Gray code: 000,001,011,010,110,111,101,100.
REQ-033 Without INV_BIST_GRAY_EN, the vector order SHALL be binary 0..7.
REQ-034 Under either setting, all other behaviour, including timing, SHALL be identical.

Verification
REQ-035 Golden NAND3, DUT_LAT=1, PASSES=1, start pulse -> busy high 9 cycles, then done=1, pass=1, err_cnt=0, first_fail_vec=0.
REQ-036 Y1 stuck at 1, DUT_LAT=1 -> err_cnt=1, first_fail_vec=3'b111, pass=0.
REQ-037 Y1 stuck at 0, PASSES=3 -> 21 mismatches, err_cnt=15 (saturated), first_fail_vec=3'b000.
REQ-038 rst=1 in the 4th DRIVE cycle -> next cycle IDLE with all outputs 0; a following start runs a full clean sweep with pass=1.
REQ-039 start held high through DRIVE -> the run is not restarted; start=1 in DONE -> new run begins and err_cnt clears.
REQ-040 INV_BIST_GRAY_EN defined, DUT_LAT=0, combinational NAND3 -> X order is the Gray sequence, no DRAIN cycle, done after 8 busy cycles, pass=1.
